// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types for the hazard / forwarding controller: forwarding-select
// encoding, controller FSM states and the shadow pipeline entry.
package hazard_pkg;

    // Register IDs are carried internally at this width and zero-extended
    // from the configured ID width, so the shared struct does not depend on
    // the NREG parameter.
    localparam int REG_W_MAX = 8;

    typedef logic [REG_W_MAX-1:0] rid_t;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,  // operand comes from the register file
        FWD_EXDM = 2'b01,  // operand comes from the EX/MEM result
        FWD_DMWB = 2'b10   // operand comes from the MEM/WB result
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_LU_STALL,
        HZ_HALT_DRAIN,
        HZ_HALTED
    } hz_state_t;

    // Shadow record of one in-flight instruction. An all-zero entry is a bubble.
    typedef struct packed {
        logic valid;
        logic wr;
        rid_t rid;
        logic load;
    } stage_ent_t;

    // Width of a register ID for a register file of nreg entries.
    function automatic int id_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side fields and pipeline-control outputs of the hazard unit.
// The pipeline (or a bench) drives through master; the hazard unit uses slave.
interface hazard_fwd_unit_if
    import hazard_pkg::*;
#(
    parameter int NREG = 8
);
    localparam int ID_W = id_width(NREG);

    // Instruction leaving decode
    logic            ID_Valid;
    logic [ID_W-1:0] ID_RS;
    logic [ID_W-1:0] ID_RT;
    logic            ID_RSUsed;
    logic            ID_RTUsed;
    logic            ID_RegWrite;
    logic [ID_W-1:0] ID_WriteReg;
    logic            ID_MemRead;
    logic            ID_Halt;

    // Pipeline events
    logic            Redirect;
    logic            MemStall;

    // Controls back to the pipeline
    fwd_sel_t        A_Sel;
    fwd_sel_t        B_Sel;
    logic            Stall;
    logic            Bubble;
    logic            Flush;
    logic            Halted;

    modport master (
        output ID_Valid, ID_RS, ID_RT, ID_RSUsed, ID_RTUsed,
               ID_RegWrite, ID_WriteReg, ID_MemRead, ID_Halt,
               Redirect, MemStall,
        input  A_Sel, B_Sel, Stall, Bubble, Flush, Halted
    );

    modport slave (
        input  ID_Valid, ID_RS, ID_RT, ID_RSUsed, ID_RTUsed,
               ID_RegWrite, ID_WriteReg, ID_MemRead, ID_Halt,
               Redirect, MemStall,
        output A_Sel, B_Sel, Stall, Bubble, Flush, Halted
    );

endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Forwarding comparison for one source operand against the EX and MEM
// shadow entries. Purely combinational; instantiated once per source.
module fwd_select
    import hazard_pkg::*;
(
    input  rid_t       i_src,        // source register ID (zero-extended)
    input  logic       i_used,       // source is really read by a valid instruction
    input  stage_ent_t i_ex,         // instruction currently in EX
    input  logic       i_mem_wr,     // MEM entry is valid and writes a register
    input  rid_t       i_mem_rid,    // MEM entry destination
    output fwd_sel_t   o_sel,
    output logic       o_load_use    // EX holds a load this source depends on
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit   = i_used & i_ex.valid & i_ex.wr & (i_ex.rid == i_src);
    assign w_mem_hit  = i_used & i_mem_wr & (i_mem_rid == i_src);
    assign o_load_use = w_ex_hit & i_ex.load;

    // Younger producer (EX) wins; a load in EX cannot forward yet, so the
    // stall logic holds the consumer until the load reaches MEM.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        o_sel = FWD_RF;
        if (w_ex_hit && !i_ex.load) begin
            o_sel = FWD_EXDM;
        end else if (w_mem_hit) begin
            o_sel = FWD_DMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard and forwarding controller for the 5-stage 16-bit core.
// Tracks destinations of the instructions in EX/MEM/WB, registers the
// forwarding selects for EX, and drives stall/bubble/flush plus halt drain.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int NREG       = 8,
    parameter int HALT_DRAIN = 3
)(
    input  logic               clk,
    input  logic               rst_n,
    hazard_fwd_unit_if.slave   bus
);

    localparam int ID_W  = id_width(NREG);
    localparam int CNT_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALT_DRAIN - 1);

    stage_ent_t       r_ex;
    stage_ent_t       r_mem;
    stage_ent_t       r_wb;
    stage_ent_t       w_dec;
    fwd_sel_t         r_a_sel;
    fwd_sel_t         r_b_sel;
    fwd_sel_t         w_a_sel;
    fwd_sel_t         w_b_sel;
    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    rid_t             w_rs;
    rid_t             w_rt;
    logic             w_adv;
    logic             w_lu_rs;
    logic             w_lu_rt;
    logic             w_load_use;
    logic             w_halt_req;
    logic             w_stall;
    logic             w_bubble;
    logic             w_squash;

    assign w_adv      = ~bus.MemStall;
    assign w_rs       = rid_t'(bus.ID_RS[ID_W-1:0]);
    assign w_rt       = rid_t'(bus.ID_RT[ID_W-1:0]);
    assign w_load_use = w_lu_rs | w_lu_rt;
    assign w_halt_req = bus.ID_Halt & bus.ID_Valid & ~bus.Redirect;

    // Shadow entry for the decode instruction; HALT and NOPs travel as bubbles.
    always_comb begin
        w_dec = '0;
        if (bus.ID_Valid && !bus.ID_Halt) begin
            w_dec.valid = 1'b1;
            w_dec.wr    = bus.ID_RegWrite;
            w_dec.rid   = rid_t'(bus.ID_WriteReg[ID_W-1:0]);
            w_dec.load  = bus.ID_MemRead;
        end
    end

    fwd_select u_fwd_rs (
        .i_src      (w_rs),
        .i_used     (bus.ID_Valid & bus.ID_RSUsed),
        .i_ex       (r_ex),
        .i_mem_wr   (r_mem.valid & r_mem.wr),
        .i_mem_rid  (r_mem.rid),
        .o_sel      (w_a_sel),
        .o_load_use (w_lu_rs)
    );

    fwd_select u_fwd_rt (
        .i_src      (w_rt),
        .i_used     (bus.ID_Valid & bus.ID_RTUsed),
        .i_ex       (r_ex),
        .i_mem_wr   (r_mem.valid & r_mem.wr),
        .i_mem_rid  (r_mem.rid),
        .o_sel      (w_b_sel),
        .o_load_use (w_lu_rt)
    );

    // Next-state and pipeline-control decode for the hazard FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;

        unique case (r_state)
            HZ_RUN: begin
                // A redirect squashes decode, so its hazard or halt never happens.
                if (bus.Redirect) begin
                    w_state_nxt = HZ_RUN;
                end else if (w_load_use) begin
                    w_stall     = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = HZ_LU_STALL;
                end else if (w_halt_req) begin
                    w_state_nxt = HZ_HALT_DRAIN;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            HZ_LU_STALL: begin
                // Bubble is now in EX and the load in MEM; hazards re-evaluate.
                w_state_nxt = HZ_RUN;
            end
            HZ_HALT_DRAIN: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = HZ_HALTED;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            HZ_HALTED: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            default: begin
                w_state_nxt = HZ_RUN;
            end
        endcase

        // A busy data memory freezes everything, including the FSM.
        if (bus.MemStall) begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_stall     = 1'b1;
            w_bubble    = 1'b0;
        end
    end

    assign w_squash = w_bubble | bus.Redirect;

    // FSM state and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HZ_RUN;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow pipeline and registered forwarding selects; both advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_a_sel <= FWD_RF;
            r_b_sel <= FWD_RF;
        end else if (w_adv) begin
            r_ex    <= w_squash ? stage_ent_t'('0) : w_dec;
            r_mem   <= r_ex;
            r_wb    <= r_mem;
            r_a_sel <= w_squash ? FWD_RF : w_a_sel;
            r_b_sel <= w_squash ? FWD_RF : w_b_sel;
        end
    end

    assign bus.A_Sel  = r_a_sel;
    assign bus.B_Sel  = r_b_sel;
    assign bus.Stall  = w_stall;
    assign bus.Bubble = w_bubble;
    assign bus.Flush  = bus.Redirect;
    assign bus.Halted = (r_state == HZ_HALTED);

    // Once halted, nothing real may remain anywhere in the shadow pipe.
    a_halted_empty: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == HZ_HALTED) |-> (r_ex == '0 && r_mem == '0 && r_wb == '0)
    );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding, load-use, redirect,
// memory freeze and halt drain, each with hand-computed expectations.
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hazard_fwd_unit_if #(.NREG(8)) bus ();

    hazard_fwd_unit #(.NREG(8), .HALT_DRAIN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                         input logic [2:0] rt, input logic rtu, input logic wr,
                         input logic [2:0] wreg, input logic ld, input logic halt);
        bus.ID_Valid    = v;
        bus.ID_RS       = rs;
        bus.ID_RSUsed   = rsu;
        bus.ID_RT       = rt;
        bus.ID_RTUsed   = rtu;
        bus.ID_RegWrite = wr;
        bus.ID_WriteReg = wreg;
        bus.ID_MemRead  = ld;
        bus.ID_Halt     = halt;
    endtask

    task automatic nop();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pipe();
        nop();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset();
        #2;
        rst_n        = 1'b0;
        bus.Redirect = 1'b0;
        bus.MemStall = 1'b0;
        nop();
        #1;
        n_checks++;
        if (bus.A_Sel !== FWD_RF) begin
            n_errors++; $display("FAIL reset_a_sel: got %0d expected 0", bus.A_Sel);
        end
        n_checks++;
        if (bus.B_Sel !== FWD_RF) begin
            n_errors++; $display("FAIL reset_b_sel: got %0d expected 0", bus.B_Sel);
        end
        n_checks++;
        if ({bus.Stall, bus.Bubble, bus.Flush, bus.Halted} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.Stall, bus.Bubble, bus.Flush, bus.Halted});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exdm_forward();
        flush_pipe();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);  // ADD r3,r1,r2
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);  // SUB r4,r3,r1
        #1;
        n_checks++;
        if (bus.Stall !== 1'b0) begin
            n_errors++; $display("FAIL exdm_stall: got %b expected 0", bus.Stall);
        end
        tick();
        n_checks++;
        if (bus.A_Sel !== FWD_EXDM) begin
            n_errors++; $display("FAIL exdm_a_sel: got %0d expected 1", bus.A_Sel);
        end
        n_checks++;
        if (bus.B_Sel !== FWD_RF) begin
            n_errors++; $display("FAIL exdm_b_sel: got %0d expected 0", bus.B_Sel);
        end
    endtask

    task automatic test_memwb_forward();
        flush_pipe();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);  // ADD r3
        tick();
        nop();
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);  // reads r3,r3
        tick();
        n_checks++;
        if (bus.A_Sel !== FWD_DMWB) begin
            n_errors++; $display("FAIL memwb_a_sel: got %0d expected 2", bus.A_Sel);
        end
        n_checks++;
        if (bus.B_Sel !== FWD_DMWB) begin
            n_errors++; $display("FAIL memwb_b_sel: got %0d expected 2", bus.B_Sel);
        end
    endtask

    task automatic test_priority();
        flush_pipe();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);  // ADD r3,r1,r2
        tick();
        drive(1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);  // ADD r3,r4,r5
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);  // reads r3,r6
        tick();
        n_checks++;
        if (bus.A_Sel !== FWD_EXDM) begin
            n_errors++; $display("FAIL prio_a_sel: got %0d expected 1", bus.A_Sel);
        end
        n_checks++;
        if (bus.B_Sel !== FWD_RF) begin
            n_errors++; $display("FAIL prio_b_sel: got %0d expected 0", bus.B_Sel);
        end
        // Unused RS must not forward even though r3 is in MEM.
        drive(1'b1, 3'd3, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.A_Sel !== FWD_RF) begin
            n_errors++; $display("FAIL unused_a_sel: got %0d expected 0", bus.A_Sel);
        end
        n_checks++;
        if (bus.B_Sel !== FWD_DMWB) begin
            n_errors++; $display("FAIL unused_b_sel: got %0d expected 2", bus.B_Sel);
        end
        // Register 0 forwards like any other register.
        flush_pipe();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);  // ADD r0
        tick();
        drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({bus.A_Sel, bus.B_Sel} !== {FWD_EXDM, FWD_EXDM}) begin
            n_errors++;
            $display("FAIL r0_sels: got %b expected 0101", {bus.A_Sel, bus.B_Sel});
        end
    endtask

    task automatic test_load_use();
        flush_pipe();
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);  // LD r2
        tick();
        drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);  // ADD r5,r2,r2
        #1;
        n_checks++;
        if ({bus.Stall, bus.Bubble, bus.Flush} !== 3'b110) begin
            n_errors++;
            $display("FAIL lu_detect: got %b expected 110", {bus.Stall, bus.Bubble, bus.Flush});
        end
        tick();
        n_checks++;
        if ({bus.Stall, bus.Bubble} !== 2'b00) begin
            n_errors++;
            $display("FAIL lu_one_cycle: got %b expected 00", {bus.Stall, bus.Bubble});
        end
        n_checks++;
        if (bus.A_Sel !== FWD_RF) begin
            n_errors++; $display("FAIL lu_bubble_sel: got %0d expected 0", bus.A_Sel);
        end
        tick();
        n_checks++;
        if ({bus.A_Sel, bus.B_Sel} !== {FWD_DMWB, FWD_DMWB}) begin
            n_errors++;
            $display("FAIL lu_sels: got %b expected 1010", {bus.A_Sel, bus.B_Sel});
        end
        nop();
    endtask

    task automatic test_redirect_hazard();
        flush_pipe();
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);  // LD r2
        tick();
        drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);  // ADD r5,r2,r2
        bus.Redirect = 1'b1;
        #1;
        n_checks++;
        if ({bus.Flush, bus.Stall, bus.Bubble} !== 3'b100) begin
            n_errors++;
            $display("FAIL redir_ctrl: got %b expected 100", {bus.Flush, bus.Stall, bus.Bubble});
        end
        tick();
        bus.Redirect = 1'b0;
        n_checks++;
        if (dut.r_state !== HZ_RUN) begin
            n_errors++; $display("FAIL redir_state: got %0d expected 0", dut.r_state);
        end
        // Squashed ADD r5 must not be seen in EX; the load r2 is now in MEM.
        drive(1'b1, 3'd5, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.Stall !== 1'b0) begin
            n_errors++; $display("FAIL redir_no_stall: got %b expected 0", bus.Stall);
        end
        tick();
        n_checks++;
        if ({bus.A_Sel, bus.B_Sel} !== {FWD_RF, FWD_DMWB}) begin
            n_errors++;
            $display("FAIL redir_sels: got %b expected 0010", {bus.A_Sel, bus.B_Sel});
        end
        nop();
    endtask

    task automatic test_memstall();
        flush_pipe();
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);  // ADD r3
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);  // SUB r4,r3,r1
        tick();
        drive(1'b1, 3'd4, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);  // reads r4,r3
        bus.MemStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({bus.Stall, bus.Bubble} !== 2'b10) begin
                n_errors++;
                $display("FAIL ms_ctrl[%0d]: got %b expected 10", i, {bus.Stall, bus.Bubble});
            end
            tick();
            n_checks++;
            if ({bus.A_Sel, bus.B_Sel} !== {FWD_EXDM, FWD_RF}) begin
                n_errors++;
                $display("FAIL ms_hold[%0d]: got %b expected 0100", i, {bus.A_Sel, bus.B_Sel});
            end
        end
        bus.MemStall = 1'b0;
        tick();
        n_checks++;
        if ({bus.A_Sel, bus.B_Sel} !== {FWD_EXDM, FWD_DMWB}) begin
            n_errors++;
            $display("FAIL ms_resume: got %b expected 0110", {bus.A_Sel, bus.B_Sel});
        end
        nop();
    endtask

    task automatic test_halt_drain();
        flush_pipe();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);  // HALT
        bus.Redirect = 1'b1;
        #1;
        n_checks++;
        if ({bus.Flush, bus.Stall} !== 2'b10) begin
            n_errors++; $display("FAIL halt_redir: got %b expected 10", {bus.Flush, bus.Stall});
        end
        tick();
        bus.Redirect = 1'b0;
        #1;
        n_checks++;
        if (dut.r_state !== HZ_RUN) begin
            n_errors++; $display("FAIL halt_redir_state: got %0d expected 0", dut.r_state);
        end
        tick();  // HALT accepted on this edge
        n_checks++;
        if ({bus.Stall, bus.Bubble, bus.Halted} !== 3'b110) begin
            n_errors++;
            $display("FAIL halt_drain0: got %b expected 110", {bus.Stall, bus.Bubble, bus.Halted});
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (bus.Halted !== (i >= 3)) begin
                n_errors++;
                $display("FAIL halt_cycle[%0d]: got %b expected %b", i, bus.Halted, (i >= 3));
            end
        end
        n_checks++;
        if ({bus.Stall, bus.Bubble} !== 2'b11) begin
            n_errors++;
            $display("FAIL halted_ctrl: got %b expected 11", {bus.Stall, bus.Bubble});
        end
    endtask

    task automatic test_reset_mid_drain();
        test_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);  // HALT
        tick();
        tick();
        rst_n = 1'b0;
        nop();
        #1;
        n_checks++;
        if ({bus.Stall, bus.Bubble, bus.Halted, bus.Flush} !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_drain_ctrl: got %b expected 0000",
                     {bus.Stall, bus.Bubble, bus.Halted, bus.Flush});
        end
        n_checks++;
        if (dut.r_state !== HZ_RUN) begin
            n_errors++; $display("FAIL rst_drain_state: got %0d expected 0", dut.r_state);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.Stall !== 1'b0) begin
            n_errors++; $display("FAIL rst_drain_residual: got %b expected 0", bus.Stall);
        end
        drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);  // ADD r3
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({bus.A_Sel, bus.B_Sel} !== {FWD_EXDM, FWD_RF}) begin
            n_errors++;
            $display("FAIL rst_drain_fwd: got %b expected 0100", {bus.A_Sel, bus.B_Sel});
        end
        nop();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        test_reset();
        test_exdm_forward();
        test_memwb_forward();
        test_priority();
        test_load_use();
        test_redirect_hazard();
        test_memstall();
        test_halt_drain();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Pipeline hazard and forwarding controller for the 5-stage 16-bit core. It watches each instruction as it leaves decode and keeps a shadow record of the destination registers of the instructions in EX, MEM and WB. From that record it drives the registered `A_Sel`/`B_Sel` forwarding selects that the execute stage consumes, plus the stall, bubble and flush controls for IF/ID and ID/EX. It also sequences halt drain-down.

## Interface
- `NREG`, default 8: number of architectural registers. Register IDs are `$clog2(NREG)` bits wide.
- `HALT_DRAIN`, default 3: cycles between halt acceptance and `Halted` assertion, covering the EX, MEM and WB drain.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ID_Valid`  in  1  decode holds a real instruction, not a NOP.
- `ID_RS`, `ID_RT`  in  3  source register IDs.
- `ID_RSUsed`, `ID_RTUsed`  in  1  the source is actually read.
- `ID_RegWrite`  in  1  the instruction writes a register.
- `ID_WriteReg`  in  3  destination register ID.
- `ID_MemRead`  in  1  the instruction is a load.
- `ID_Halt`  in  1  the instruction is HALT.
- `Redirect`  in  1  execute resolved a taken branch or jump this cycle.
- `MemStall`  in  1  data memory busy; freezes the whole pipeline.
- `A_Sel`, `B_Sel`  out  2  forwarding selects for the instruction in EX: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- `Stall`  out  1  hold PC and IF/ID.
- `Bubble`  out  1  load a NOP into ID/EX.
- `Flush`  out  1  squash IF/ID.
- `Halted`  out  1  the pipeline has drained after HALT.

## Operation
- Shadow stages `ex_q`, `mem_q` and `wb_q` each hold `{valid, wr, reg, load}`.
- On an advancing edge, `ex_q` receives the decode entry, or an invalid entry when `Bubble` or `Flush` is asserted. `mem_q` receives `ex_q`, and `wb_q` receives `mem_q`.
- Forwarding is computed combinationally from the decode fields and registered into `A_Sel`/`B_Sel` on the same edge that moves the instruction into EX.
- Rules for RS (RT is identical):
  - If `ex_q` is valid, writes a register, is not a load, and its `reg` equals `ID_RS`, select 01.
  - Otherwise, if `mem_q` is valid, writes a register, and its `reg` equals `ID_RS`, select 10.
  - Otherwise select 00. Writes in the WB stage are covered by the register file's write-before-read, so no forward is needed.
  - If `ID_RSUsed` is 0, select 00.
- The younger producer, `ex_q`, has priority.
- Load-use hazard: `ex_q` is a valid load and matches a used source. On this condition `Stall` and `Bubble` are asserted for exactly one cycle. After the bubble, the load sits in `mem_q` and the dependent instruction receives select 10.
- FSM states: RUN, LU_STALL, HALT_DRAIN, HALTED.
  - RUN → LU_STALL on a load-use hazard.
  - LU_STALL → RUN unconditionally, with hazards re-evaluated.
  - RUN → HALT_DRAIN when `ID_Halt & ID_Valid & ~Redirect`. HALT itself enters `ex_q` as invalid. The counter loads `HALT_DRAIN-1`.
  - HALT_DRAIN: `Stall` and `Bubble` are held high while the counter decrements. At 0 the FSM moves to HALTED.
  - HALTED: `Stall` and `Bubble` stay high and `Halted` is 1 until reset.
- `Redirect`: `Flush` equals `Redirect`, and the decode entry is squashed. Redirect overrides a load-use hazard and a halt detected in the same cycle; the FSM stays in RUN.
- `MemStall`: all shadow stages, selects, FSM state and the counter hold. `Stall` is forced to 1 and `Bubble` to 0.
- Register 0 is an ordinary register and forwards like any other.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - All shadow entries are invalid.
  - `A_Sel` = `B_Sel` = 00.
  - FSM = RUN and the counter = 0.
  - `Stall`, `Bubble` and `Halted` are all 0.
  - `Flush` = `Redirect`, which is 0 during reset by upstream contract.
- `A_Sel`/`B_Sel` are registered. They are valid for the whole cycle the instruction occupies EX, with zero combinational path to the execute inputs.
- `Stall`, `Bubble` and `Flush` are combinational from decode inputs and state, and are sampled by pipeline registers at the next edge.
- A load-use hazard costs exactly 1 cycle. `Halted` rises `HALT_DRAIN` cycles after the edge that accepts HALT.
- Reset mid-drain or mid-stall returns the block to RUN with no residual stall.

## Structure
- A shared package `hazard_pkg` holds:
  - the `fwd_sel_t` encoding (`FWD_RF`=00, `FWD_EXDM`=01, `FWD_DMWB`=10);
  - the `hz_state_t` enum;
  - the `stage_ent_t` struct.
- The sub-module `fwd_select` is the pure combinational comparison of one source against `ex_q`/`mem_q`. It is instantiated twice, once for RS and once for RT.

## Test plan
- **EX/MEM forward:** ADD r3 followed immediately by SUB r4,r3,r1 → SUB in EX sees `A_Sel`=01 and `B_Sel`=00, with no stall.
- **MEM/WB forward and priority:**
  - ADD r3, then NOP, then an instruction reading r3 → that instruction sees select 10.
  - ADD r3, ADD r3, then a reader of r3 → the reader sees select 01.
- **Load-use:** LD r2 followed by ADD r5,r2,r2 → `Stall`=`Bubble`=1 for 1 cycle. The ADD then sees `A_Sel`=`B_Sel`=10 in EX.
- **Redirect during hazard:** `Redirect`=1 in the same cycle a load-use hazard is detected → `Flush`=1, `Stall`=0, FSM stays in RUN, and `ex_q` receives an invalid entry.
- **MemStall freeze:** assert `MemStall` for 4 cycles mid-stream → selects and shadow entries are unchanged and `Stall`=1. Forwarding resumes correctly after release.
- **Halt drain:**
  - HALT accepted → `Halted`=1 exactly 3 cycles later and stays high.
  - `rst_n` pulsed low in HALT_DRAIN → all outputs return to 0 immediately.
